// File: rtl/spi_frame_sender.sv
// Buffered CLK/DATA/LOAD/STOP frame transmitter: releases complete messages MSB-first.
// Optional build macro SPI_PARITY_EN appends an even-parity bit period to every word.
module spi_frame_sender #(
    parameter int DEPTH    = 64,
    parameter int CLK_DIV  = 2,
    parameter int GAP_BITS = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] WR_DATA,
    input  logic        WR_REQ,
    input  logic        WR_LAST,
    output logic        FULL,
    output logic        OVF,
    output logic        SPI_CLK,
    output logic        SPI_DATA,
    output logic        SPI_LOAD,
    output logic        SPI_STOP,
    output logic        BUSY,
    output logic [7:0]  MSG_CNT
);
    // state | meaning
    // IDLE  | nothing to send; LOAD/STOP/DATA low
    // FETCH | word popped into shift register, waiting for next bit-period start
    // SHIFT | LOAD high, one bit per period, MSB first
    // GAP   | LOAD low between words of a message (also parks when drain empties buffer)
    // STOP  | one bit period with STOP high after the final word
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_GAP, S_STOP} state_t;

`ifdef SPI_PARITY_EN
    localparam int SR_W = 17;
`else
    localparam int SR_W = 16;
`endif
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_BITS > 2) ? $clog2(GAP_BITS) : 1;

    state_t            state, next_state;
    logic [16:0]       mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [7:0]        msg_cnt;
    logic              ovf;
    logic              spi_clk;
    logic [DIV_W-1:0]  div_cnt;
    logic [SR_W-1:0]   shift_reg;
    logic              last_flag;
    logic [4:0]        bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              drain_open;
    logic              full, empty, wr_en, pop, bit_tick;
    logic              inc_msg, dec_msg, forced_start;
    logic [16:0]       rd_word;
    logic              out_data, out_load, out_stop, out_busy;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign wr_en    = WR_REQ && !full;
    assign rd_word  = mem[rd_ptr];
    assign bit_tick = (div_cnt == '0) && spi_clk;

    always_ff @(posedge CLK) begin
        if (RST) begin
            spi_clk <= 1'b0;
            div_cnt <= DIV_W'(CLK_DIV - 1);
        end else if (div_cnt == '0) begin
            spi_clk <= ~spi_clk;
            div_cnt <= DIV_W'(CLK_DIV - 1);
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= {WR_LAST, WR_DATA};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (WR_REQ && full) ovf <= 1'b1;
        end
    end

    // A forced drain has already started the open message, so its closing write is not counted.
    assign forced_start = (state == S_IDLE) && (next_state == S_FETCH) && (msg_cnt == 8'd0);
    assign dec_msg      = (state == S_IDLE) && (next_state == S_FETCH) && (msg_cnt != 8'd0);
    assign inc_msg      = wr_en && WR_LAST && !drain_open;

    always_ff @(posedge CLK) begin
        if (RST) begin
            msg_cnt    <= 8'd0;
            drain_open <= 1'b0;
        end else begin
            if (inc_msg && !dec_msg && msg_cnt != 8'd255) msg_cnt <= msg_cnt + 1'b1;
            else if (dec_msg && !inc_msg)                 msg_cnt <= msg_cnt - 1'b1;
            if (forced_start)             drain_open <= 1'b1;
            else if (wr_en && WR_LAST)    drain_open <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && (msg_cnt != 8'd0 || full)) begin
                    next_state = S_FETCH;
                    pop        = 1'b1;
                end
            end
            S_FETCH: if (bit_tick) next_state = S_SHIFT;
            S_SHIFT: begin
                if (bit_tick && bit_cnt == 5'd0) begin
                    if (last_flag) begin
                        next_state = S_STOP;
                    end else if (GAP_BITS == 0 && !empty) begin
                        next_state = S_SHIFT;
                        pop        = 1'b1;
                    end else begin
                        next_state = S_GAP;
                    end
                end
            end
            // Fetch starts inside the last gap period so FETCH absorbs no extra bit period.
            S_GAP: begin
                if (gap_cnt == '0 && !empty) begin
                    next_state = S_FETCH;
                    pop        = 1'b1;
                end
            end
            S_STOP:  if (bit_tick) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_reg <= '0;
            last_flag <= 1'b0;
            bit_cnt   <= 5'd0;
            gap_cnt   <= '0;
        end else begin
            if (pop) begin
`ifdef SPI_PARITY_EN
                shift_reg <= {rd_word[15:0], ^rd_word[15:0]};
`else
                shift_reg <= rd_word[15:0];
`endif
                last_flag <= rd_word[16];
                bit_cnt   <= 5'(SR_W - 1);
            end else if (state == S_SHIFT && bit_tick) begin
                shift_reg <= shift_reg << 1;
                if (bit_cnt != 5'd0) bit_cnt <= bit_cnt - 1'b1;
            end
            if (state == S_SHIFT && next_state == S_GAP)
                gap_cnt <= (GAP_BITS > 0) ? GAP_W'(GAP_BITS - 1) : '0;
            else if (state == S_GAP && bit_tick && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
        end
    end

    always_comb begin
        out_data = 1'b0;
        out_load = 1'b0;
        out_stop = 1'b0;
        out_busy = (state != S_IDLE);
        case (state)
            S_SHIFT: begin
                out_load = 1'b1;
                out_data = shift_reg[SR_W-1];
            end
            S_STOP:  out_stop = 1'b1;
            default: ;
        endcase
    end

    assign FULL     = full;
    assign OVF      = ovf;
    assign SPI_CLK  = spi_clk;
    assign SPI_DATA = out_data;
    assign SPI_LOAD = out_load;
    assign SPI_STOP = out_stop;
    assign BUSY     = out_busy;
    assign MSG_CNT  = msg_cnt;

endmodule

// File: tb/tb_spi_frame_sender.sv
// Scoreboard bench for spi_frame_sender (DEPTH=4, CLK_DIV=2, GAP_BITS=1); SPI_PARITY_EN-aware.
module tb_spi_frame_sender;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] WR_DATA = 16'h0;
    logic        WR_REQ = 1'b0;
    logic        WR_LAST = 1'b0;
    logic        FULL, OVF, SPI_CLK, SPI_DATA, SPI_LOAD, SPI_STOP, BUSY;
    logic [7:0]  MSG_CNT;

    spi_frame_sender #(.DEPTH(4), .CLK_DIV(2), .GAP_BITS(1)) dut (
        .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_REQ(WR_REQ), .WR_LAST(WR_LAST),
        .FULL(FULL), .OVF(OVF), .SPI_CLK(SPI_CLK), .SPI_DATA(SPI_DATA),
        .SPI_LOAD(SPI_LOAD), .SPI_STOP(SPI_STOP), .BUSY(BUSY), .MSG_CNT(MSG_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          kind;   // 0 = word, 1 = stop
        logic [16:0] data;
        int          nbits;
        int          gap;    // idle bit periods before the word, -1 = don't care
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [15:0] w, input int gap);
        exp_t e;
        e.kind = 0;
        e.gap  = gap;
`ifdef SPI_PARITY_EN
        e.data  = {w, ^w};
        e.nbits = 17;
`else
        e.data  = {1'b0, w};
        e.nbits = 16;
`endif
        exp_q.push_back(e);
    endtask

    task automatic push_stop();
        exp_t e;
        e.kind = 1; e.data = '0; e.nbits = 0; e.gap = -1;
        exp_q.push_back(e);
    endtask

    // Monitor: samples the serial link at each SPI_CLK rise, reconstructs words and STOPs.
    initial begin
        logic        prev_sclk;
        logic [16:0] sh;
        int          nb, idle, gap_cap, lcyc;
        exp_t        e;
        prev_sclk = 0; sh = '0; nb = 0; idle = 0; gap_cap = 0; lcyc = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                nb = 0; lcyc = 0; prev_sclk = 0;
            end else begin
                if (SPI_LOAD) lcyc++;
                if (SPI_CLK && !prev_sclk) begin
                    if (SPI_LOAD) begin
                        if (nb == 0) begin
                            gap_cap = idle; idle = 0; sh = '0;
                        end
                        sh = {sh[15:0], SPI_DATA};
                        nb++;
                    end else begin
                        if (nb > 0) begin
                            if (exp_q.size() == 0) begin
                                n_checks++; n_errors++;
                                $display("FAIL unexpected_word: actual %h (%0d bits) required none", sh, nb);
                            end else begin
                                e = exp_q.pop_front();
                                check("event_kind_word", 32'(0), 32'(e.kind));
                                check("word_data", 32'(sh), 32'(e.data));
                                check("word_bits", 32'(nb), 32'(e.nbits));
                                check("load_cycles", 32'(lcyc), 32'(e.nbits * 4));
                                if (e.gap >= 0) check("gap_periods", 32'(gap_cap), 32'(e.gap));
                            end
                            nb = 0; lcyc = 0;
                        end
                        if (SPI_STOP) begin
                            if (exp_q.size() == 0) begin
                                n_checks++; n_errors++;
                                $display("FAIL unexpected_stop: actual stop required none");
                            end else begin
                                e = exp_q.pop_front();
                                check("event_kind_stop", 32'(1), 32'(e.kind));
                                check("stop_data", 32'(SPI_DATA), 32'(0));
                            end
                        end else begin
                            idle++;
                        end
                    end
                end
                prev_sclk = SPI_CLK;
            end
        end
    end

    task automatic wr(input logic [15:0] d, input logic last);
        @(negedge CLK);
        WR_DATA = d; WR_REQ = 1'b1; WR_LAST = last;
    endtask

    task automatic wr_end();
        @(negedge CLK);
        WR_REQ = 1'b0; WR_LAST = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge CLK); RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        repeat (3) @(negedge CLK);
        while (BUSY && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check(name, 32'(BUSY), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_spi_clk",  32'(SPI_CLK),  32'(0));
        check("rst_spi_data", 32'(SPI_DATA), 32'(0));
        check("rst_spi_load", 32'(SPI_LOAD), 32'(0));
        check("rst_spi_stop", 32'(SPI_STOP), 32'(0));
        check("rst_full",     32'(FULL),     32'(0));
        check("rst_ovf",      32'(OVF),      32'(0));
        check("rst_busy",     32'(BUSY),     32'(0));
        check("rst_msg_cnt",  32'(MSG_CNT),  32'(0));
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Single-word message
        push_word(16'hA5C3, -1);
        push_stop();
        wr(16'hA5C3, 1'b1);
        wr_end();
        wait_idle("t1_idle_timeout", 300);
        check("t1_queue_drained", 32'(exp_q.size()), 32'(0));

        // Three-word message, gap of one bit period between words
        push_word(16'h1234, -1);
        push_word(16'hBEEF, 1);
        push_word(16'h0F0F, 1);
        push_stop();
        wr(16'h1234, 1'b0);
        wr(16'hBEEF, 1'b0);
        wr(16'h0F0F, 1'b1);
        wr_end();
        check("t2_msg_cnt_before", 32'(MSG_CNT), 32'(1));
        check("t2_busy_before",    32'(BUSY),    32'(0));
        @(negedge CLK);
        check("t2_msg_cnt_after",  32'(MSG_CNT), 32'(0));
        check("t2_busy_after",     32'(BUSY),    32'(1));
        wait_idle("t2_idle_timeout", 600);
        check("t2_queue_drained", 32'(exp_q.size()), 32'(0));

        // Incomplete message stays buffered
        wr(16'h1111, 1'b0);
        wr(16'h2222, 1'b0);
        wr_end();
        repeat (60) @(negedge CLK);
        check("t3_msg_cnt", 32'(MSG_CNT), 32'(0));
        check("t3_busy",    32'(BUSY),    32'(0));
        check("t3_full",    32'(FULL),    32'(0));
        pulse_reset();

        // Overflow and forced drain
        push_word(16'h0001, -1);
        push_word(16'h8000, 1);
        push_word(16'hFFFF, 1);
        push_word(16'h5A5A, 1);
        wr(16'h0001, 1'b0);
        wr(16'h8000, 1'b0);
        wr(16'hFFFF, 1'b0);
        wr(16'h5A5A, 1'b0);
        wr(16'h7777, 1'b0);
        check("t4_full_after_4", 32'(FULL), 32'(1));
        check("t4_ovf_before",   32'(OVF),  32'(0));
        wr_end();
        check("t4_ovf_after",    32'(OVF),  32'(1));
        check("t4_full_drain",   32'(FULL), 32'(0));
        k = 0;
        while (exp_q.size() != 0 && k < 800) begin
            @(negedge CLK);
            k++;
        end
        check("t4_queue_drained", 32'(exp_q.size()), 32'(0));
        repeat (20) @(negedge CLK);
        check("t4_parked_busy", 32'(BUSY),     32'(1));
        check("t4_no_stop",     32'(SPI_STOP), 32'(0));
        check("t4_ovf_sticky",  32'(OVF),      32'(1));
        pulse_reset();
        check("t4_ovf_cleared", 32'(OVF), 32'(0));

        // Reset in the middle of a word
        wr(16'hFFFF, 1'b1);
        wr_end();
        k = 0;
        while (!SPI_LOAD && k < 200) begin
            @(negedge CLK);
            k++;
        end
        check("t5_load_seen", 32'(SPI_LOAD), 32'(1));
        repeat (30) @(negedge CLK);
        check("t5_mid_load", 32'(SPI_LOAD), 32'(1));
        check("t5_mid_data", 32'(SPI_DATA), 32'(1));
        RST = 1'b1;
        @(negedge CLK);
        check("t5_rst_outs", 32'({SPI_CLK, SPI_DATA, SPI_LOAD, SPI_STOP, BUSY, FULL, OVF}), 32'(0));
        check("t5_rst_msg_cnt", 32'(MSG_CNT), 32'(0));
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        push_word(16'h3C5A, -1);
        push_stop();
        wr(16'h3C5A, 1'b1);
        wr_end();
        wait_idle("t5_idle_timeout", 300);

        // Parity-sensitive words (16 or 17 bit periods depending on build)
        push_word(16'h0001, -1);
        push_stop();
        wr(16'h0001, 1'b1);
        wr_end();
        wait_idle("t6a_idle_timeout", 300);
        push_word(16'h0003, -1);
        push_stop();
        wr(16'h0003, 1'b1);
        wr_end();
        wait_idle("t6b_idle_timeout", 300);

        repeat (10) @(negedge CLK);
        check("final_queue_empty", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_frame_sender.md
Name: spi_frame_sender

Overview:
- Transmit end of the 4-wire source link (CLK/DATA/LOAD/STOP) that the redirector receives on RX_CLK/RX_DATA/RX_LOAD/RX_STOP.
- Buffers 16-bit words written by local logic and releases them only as complete messages. Serializes each message MSB-first with LOAD framing each word and a STOP pulse after the last word.
- Used on remote/emulator boards and as the stimulus source in redirector benches.

Parameters:
- DEPTH, 64, word buffer depth; power of 2, 4..256.
- CLK_DIV, 2, system-clock cycles per SPI_CLK half-period; >=1.
- GAP_BITS, 1, idle bit periods (LOAD low) between consecutive words of one message; >=0.

Ports:
- CLK  in  1  system clock; all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- WR_DATA  in  16  word to buffer.
- WR_REQ  in  1  write strobe; one word per asserted cycle.
- WR_LAST  in  1  qualifies WR_REQ: this word ends a message.
- FULL  out  1  buffer holds DEPTH words.
- OVF  out  1  sticky: write attempted while FULL.
- SPI_CLK  out  1  serial clock.
- SPI_DATA  out  1  serial data.
- SPI_LOAD  out  1  high during every data bit of a word.
- SPI_STOP  out  1  high for one bit period after a message's final word.
- BUSY  out  1  serializer not in IDLE.
- MSG_CNT  out  8  complete messages buffered, not yet started; saturates at 255.

Behaviour:
- Buffer:
  - Circular, DEPTH entries, 17 bits each (word plus last flag).
  - Write is accepted when WR_REQ=1 and FULL=0. A write while FULL is dropped and sets OVF; OVF clears only on RST.
  - An accepted write with WR_LAST=1 increments MSG_CNT.
  - Simultaneous read and write on one cycle: both take effect and the count is unchanged.
- Bit timing:
  - Bit period = 2*CLK_DIV cycles.
  - SPI_CLK is low for the first CLK_DIV cycles and high for the second.
  - SPI_DATA, SPI_LOAD and SPI_STOP change only at bit-period start (SPI_CLK falling). The receiver samples on SPI_CLK rising.
  - SPI_CLK runs continuously, including in IDLE.
- State machine (IDLE, FETCH, SHIFT, GAP, STOP):
  - IDLE -> FETCH when MSG_CNT>0, or when FULL=1 with MSG_CNT=0 (forced drain, which prevents deadlock on oversized messages). MSG_CNT decrements on leaving IDLE with MSG_CNT>0.
  - FETCH: reads one word into the shift register and waits for the next bit-period boundary. Lasts at most 2*CLK_DIV cycles.
  - SHIFT: 16 bit periods with SPI_LOAD=1, SPI_DATA = bit 15 down to bit 0.
  - After bit 0:
    - last flag set -> STOP.
    - else, if the buffer is empty (forced drain caught up with writer) -> wait in GAP until a word is present.
    - else -> GAP (GAP_BITS periods; skipped when 0) -> FETCH.
  - STOP: one bit period, SPI_STOP=1, SPI_LOAD=0, SPI_DATA=0, then IDLE.
- Latency: a WR_LAST write accepted while IDLE with an empty buffer gives SPI_LOAD=1 at the first bit-period start at least 2 cycles later.
- Reset values: SPI_CLK=0, SPI_DATA=0, SPI_LOAD=0, SPI_STOP=0, FULL=0, OVF=0, BUSY=0, MSG_CNT=0. Buffer pointers are cleared.
- Reset mid-frame: all outputs go to reset values on the next edge and the partial message is discarded. No STOP is emitted.
- Idle outputs: SPI_LOAD=0, SPI_STOP=0, SPI_DATA=0.

Optional Feature:
- Macro: SPI_PARITY_EN.
- Defined: each word carries a 17th bit period, still with SPI_LOAD=1, holding even parity, i.e. XOR of the 16 data bits. A word lasts 17 bit periods.
- Undefined: 16 bit periods per word and no parity logic.

Test Plan:
- CLK_DIV=2, write 0xA5C3 with WR_LAST=1:
  - SPI_LOAD high for exactly 16 bit periods (64 cycles).
  - Bits sampled at SPI_CLK rising = 1010_0101_1100_0011.
  - One SPI_STOP period follows; BUSY returns to 0.
- Write 3 words, last flag on word 3, GAP_BITS=1:
  - Three LOAD windows, each separated by 1 idle bit period.
  - STOP only after word 3; MSG_CNT 1 -> 0 when transmission starts.
- Words without WR_LAST: no serial activity and MSG_CNT=0.
- DEPTH=4: write 5 words in consecutive cycles with WR_LAST=0 and no read.
  - FULL=1 after the 4th write; 5th dropped, OVF=1.
  - Forced drain then sends 4 words with no STOP.
- Assert RST during bit 7 of a word: next cycle all outputs are 0 and MSG_CNT=0. A fresh message afterwards transmits correctly.
- SPI_PARITY_EN defined, word 0x0001: 17 LOAD bit periods with parity bit = 1. Word 0x0003: parity bit = 0.
